sipo_rx: RTL
============

SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 Parameter WIDTH, default 4, word width in bits (>=2).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 ser_in  input  1  serial data, LSB first.
REQ-005 ser_valid  input  1  ser_in carries a bit this cycle.
REQ-006 frame_start  input  1  qualified by ser_valid; marks bit 0 of a word.
REQ-007 dout  output  WIDTH  assembled word.
REQ-008 dout_valid  output  1  dout holds an unconsumed word.
REQ-009 dout_ready  input  1  consumer accepts dout when dout_valid=1.
REQ-010 overrun  output  1  sticky; a completed word was dropped.
REQ-011 parity_err  output  1  sticky; parity mismatch seen.

Function
REQ-012 States: IDLE, SHIFT, PARITY; the FSM shall ignore all cycles with ser_valid=0 (no state, counter or shift change).
REQ-013 IDLE: ser_valid=1 with frame_start=1 shall capture the bit as bit 0, set bit count to 1 and go to SHIFT; ser_valid=1 without frame_start shall be discarded.
REQ-014 SHIFT: each valid bit shall shift in as shift={ser_in, shift[WIDTH-1:1]}, count increments.
REQ-015 On the WIDTH-th data bit the word is complete; next state IDLE (macro off) or PARITY (macro on).
REQ-016 frame_start=1 with ser_valid=1 in SHIFT or PARITY shall abort the partial word silently and restart with this bit as bit 0.
REQ-017 A completed (and, with macro on, parity-checked) word shall load into the output register with dout_valid=1 on the clock edge after its final bit; latency = 1 cycle.
REQ-018 dout and dout_valid shall stay stable until dout_valid&&dout_ready; on that cycle dout_valid falls unless a new word loads in the same cycle.
REQ-019 Completion while dout_valid=1 and dout_ready=0: new word dropped, dout unchanged, overrun set.
REQ-020 Completion while dout_valid=1 and dout_ready=1: new word loads, dout_valid stays 1, no overrun.
REQ-021 overrun and parity_err clear only on reset.

Reset
REQ-022 Reset shall force state IDLE, count 0, shift 0, dout 0, dout_valid 0, overrun 0, parity_err 0.
REQ-023 Reset mid-word shall discard the partial word; no dout_valid pulse.

Configuration
REQ-024 Macro SIPO_RX_PARITY_EN defined: after the WIDTH data bits one further valid bit is even parity (XOR of data and parity = 0); mismatch sets parity_err and the word is still delivered.
REQ-025 Macro SIPO_RX_PARITY_EN undefined: no PARITY state, word complete after WIDTH bits, parity_err tied 0.

Structure
REQ-026 Package sipo_rx_pkg shall hold the state enum type and the default WIDTH constant.
REQ-027 The output holding register and its valid/ready/overrun logic shall be sub-module sipo_rx_outbuf.

Verification (WIDTH=4)
REQ-028 frame_start with bits 1,0,1,1 on consecutive cycles, dout_ready=1 -> dout=4'hD, dout_valid high one cycle, one cycle after the last bit.
REQ-029 Two words 4'hD then 4'h3, dout_ready=0 throughout -> dout=4'hD held, overrun=1 after second word's last bit.
REQ-030 Bits 1,0 then ser_valid=0 for 5 cycles then 1,1 -> dout=4'hD; gaps do not affect assembly.
REQ-031 frame_start at bit 2 of a word, then bits 0,1,1,0 -> dout=4'h6, no flag set.
REQ-032 reset asserted after 2 bits, then full word 4'hA -> only 4'hA delivered, all flags 0.
REQ-033 Macro on: data 4'hD plus parity bit 0 -> dout=4'hD, parity_err=1; with parity bit 1 -> parity_err stays 0.

Source files
------------

// File: rtl/sipo_rx_pkg.sv
// Shared types and defaults for the serial-in/parallel-out receiver.
package sipo_rx_pkg;
   localparam int WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;
endpackage

// File: rtl/sipo_rx_outbuf.sv
// Output holding register for sipo_rx: valid/ready handshake plus sticky overrun.
import sipo_rx_pkg::*;

module sipo_rx_outbuf #(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             dout_ready,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             overrun
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         overrun    <= 1'b0;
      end else if (load) begin
         // a full, unaccepted buffer keeps its word; the newcomer is lost
         if (dout_valid && !dout_ready) begin
            overrun <= 1'b1;
         end else begin
            dout       <= din;
            dout_valid <= 1'b1;
         end
      end else if (dout_valid && dout_ready) begin
         dout_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver, LSB first, framed by frame_start.
// Optional even-parity bit after each word when SIPO_RX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a valid bit with frame_start
// SHIFT  | collecting data bits 1..WIDTH-1
// PARITY | data complete, waiting for the parity bit (SIPO_RX_PARITY_EN only)
import sipo_rx_pkg::*;

module sipo_rx #(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ser_in,
   input  logic             ser_valid,
   input  logic             frame_start,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             overrun,
   output logic             parity_err
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state, state_nx;
   logic [CW-1:0]    count, count_nx;
   logic [WIDTH-1:0] shift, shift_nx;
   logic [WIDTH-1:0] word;
   logic             word_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         shift <= '0;
      end else begin
         state <= state_nx;
         count <= count_nx;
         shift <= shift_nx;
      end
   end

`ifdef SIPO_RX_PARITY_EN
   logic perr_set;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         parity_err <= 1'b0;
      else if (perr_set)
         parity_err <= 1'b1;
   end
`else
   assign parity_err = 1'b0;
`endif

   always_comb begin
      state_nx  = state;
      count_nx  = count;
      shift_nx  = shift;
      word      = shift;
      word_done = 1'b0;
`ifdef SIPO_RX_PARITY_EN
      perr_set  = 1'b0;
`endif
      if (ser_valid) begin
         // frame_start always wins: any partial word is dropped silently
         if (frame_start) begin
            state_nx = SHIFT;
            count_nx = CW'(1);
            shift_nx = {ser_in, {(WIDTH-1){1'b0}}};
         end else begin
            case (state)
               SHIFT: begin
                  shift_nx = {ser_in, shift[WIDTH-1:1]};
                  count_nx = count + 1'b1;
                  if (count == CW'(WIDTH - 1)) begin
`ifdef SIPO_RX_PARITY_EN
                     state_nx = PARITY;
`else
                     state_nx  = IDLE;
                     word_done = 1'b1;
                     word      = shift_nx;
`endif
                  end
               end
`ifdef SIPO_RX_PARITY_EN
               PARITY: begin
                  state_nx  = IDLE;
                  word_done = 1'b1;
                  word      = shift;
                  perr_set  = ^{shift, ser_in};
               end
`endif
               default: ;
            endcase
         end
      end
   end

   sipo_rx_outbuf #(.WIDTH(WIDTH)) u_outbuf (
      .clk        (clk),
      .reset      (reset),
      .load       (word_done),
      .din        (word),
      .dout_ready (dout_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .overrun    (overrun)
   );

endmodule
